keycode_event_ctrl: RTL

//  Avalon-MM slave that replaces the plain keycode PIO. The NIOS USB-HID driver

---
 rtl/keycode_pkg.sv | 16 +
 rtl/keycode_evt_fifo.sv | 54 +++++
 rtl/keycode_event_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode event controller.
package keycode_pkg;
  localparam int KEY_W = 8;

  localparam logic [1:0] REG_KEY  = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  typedef struct packed {
    logic [KEY_W-1:0] code;
    logic             press;
  } evt_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;
endpackage

// File: rtl/keycode_evt_fifo.sv
// Synchronous show-ahead event FIFO with flush and saturating occupancy count.
module keycode_evt_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok, w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok) & ~i_flush;
  assign o_drop    = i_push & o_full & ~w_pop_ok;
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end
endmodule

// File: rtl/keycode_event_ctrl.sv
// Avalon-MM keycode slave: turns held-keycode changes into queued press/release events.
module keycode_event_ctrl
  import keycode_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             waitrequest,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KEY_W-1:0] evt_code,
  output logic             evt_press,
  output logic [KEY_W-1:0] held_code,
  output logic             irq
);
  state_t           r_state;
  logic [KEY_W-1:0] r_held, r_pend_code;
  logic             r_ovf;

  logic             w_wr, w_key_wr, w_ctrl_wr, w_changed;
  logic [KEY_W-1:0] w_new;
  logic             w_push, w_drop, w_empty, w_fifo_full;
  evt_t             w_evt, w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_unused;

  assign w_wr      = chipselect & ~write_n & ~waitrequest;
  assign w_key_wr  = w_wr & (address == REG_KEY);
  assign w_ctrl_wr = w_wr & (address == REG_CTRL);
  assign w_new     = writedata[KEY_W-1:0];
  assign w_changed = w_key_wr & (w_new != r_held);
  assign w_unused  = ^{writedata[31:KEY_W], w_fifo_full};

  // Release of the old key goes first; a replacing press follows from PEND.
  always_comb begin
    w_push = 1'b0;
    w_evt  = '0;
    if (r_state == ST_PEND) begin
      w_push = 1'b1;
      w_evt  = '{code: r_pend_code, press: 1'b1};
    end else if (w_changed) begin
      w_push = 1'b1;
      if (r_held != '0) w_evt = '{code: r_held, press: 1'b0};
      else              w_evt = '{code: w_new,  press: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_held      <= '0;
      r_pend_code <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_key_wr) r_held <= w_new;
      case (r_state)
        ST_IDLE: if (w_changed && r_held != '0 && w_new != '0) begin
          r_pend_code <= w_new;
          r_state     <= ST_PEND;
        end
        ST_PEND: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ctrl_wr) r_ovf <= 1'b0;
    end
  end

  keycode_evt_fifo #(.W($bits(evt_t)), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (evt_ready),
    .i_flush (w_ctrl_wr & writedata[0]),
    .i_data  (w_evt),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  always_comb begin
    readdata = '0;
    case (address)
      REG_KEY:  readdata[KEY_W-1:0] = r_held;
      REG_STAT: begin
        readdata[8]         = r_ovf;
        readdata[CNT_W-1:0] = w_count;
      end
      default:  readdata = '0;
    endcase
  end

  assign waitrequest = (r_state == ST_PEND);
  assign evt_valid   = ~w_empty;
  assign evt_code    = w_head.code;
  assign evt_press   = w_head.press;
  assign held_code   = r_held;
  assign irq         = r_ovf;
endmodule
